// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transmit framer.
package spi_pkg;

    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_GAP_CYCLES = 2;
    localparam int unsigned GAP_W          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SEND  = 2'd2,
        TRAIL = 2'd3
    } framer_state_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous FIFO of {last, data} entries feeding the framer.
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = DEF_DATA_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign head_o     = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so a full FIFO still takes a push alongside it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_i && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/spi_tx_framer.sv
// Chip-select framing stage between the host byte port and the SPI shifter.
module spi_tx_framer
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_last,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic                    cs_n,
    output logic                    busy
);

    localparam int unsigned ENTRY_W = DATA_W + 1;

    framer_state_t      state_q;
    logic [GAP_W-1:0]   gap_q;
    logic [ENTRY_W-1:0] head;
    logic               head_last;
    logic               pop;

    assign head_last = head[DATA_W];
    assign tx_data   = head[DATA_W-1:0];

    // Handshake outputs decode only registered state and registered occupancy.
    assign tx_valid = (state_q == SEND) && !empty;
    assign cs_n     = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign pop      = tx_valid && tx_ready;

    spi_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_en),
        .push_data_i ({wr_last, wr_data}),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .overflow_o  (overflow)
    );

    // Frame sequencing; TRAIL holds cs_n low for GAP_CYCLES after the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    state_q <= SEND;
                end
                SEND: begin
                    if (pop && head_last) begin
                        state_q <= TRAIL;
                        gap_q   <= GAP_W'(GAP_CYCLES);
                    end
                end
                TRAIL: begin
                    if (gap_q <= GAP_W'(1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
